// File: rtl/ipg_pkg.sv
// Shared constants, block-type decode and FSM state type for the IPG buffer scheduler.
package ipg_pkg;

   localparam logic [1:0] SYNC_DATA = 2'b10;
   localparam logic [1:0] SYNC_CTRL = 2'b01;

   localparam logic [7:0] BLOCK_TYPE_IDLE  = 8'h1e;
   localparam logic [7:0] BLOCK_TYPE_START = 8'h78;
   localparam logic [7:0] BLOCK_TYPE_T0    = 8'h87;
   localparam logic [7:0] BLOCK_TYPE_T1    = 8'h99;
   localparam logic [7:0] BLOCK_TYPE_T2    = 8'haa;
   localparam logic [7:0] BLOCK_TYPE_T3    = 8'hb4;
   localparam logic [7:0] BLOCK_TYPE_T4    = 8'hcc;
   localparam logic [7:0] BLOCK_TYPE_T5    = 8'hd2;
   localparam logic [7:0] BLOCK_TYPE_T6    = 8'he1;
   localparam logic [7:0] BLOCK_TYPE_T7    = 8'hff;

   localparam logic [63:0] IDLE_BLOCK = 64'h1e;
   localparam logic [63:0] ERR_BLOCK  = {{8{7'h1e}}, 8'h1e};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NET  = 2'd1,
      IPG  = 2'd2
   } state_t;

   // A control block whose type byte is one of the eight terminate codes ends a frame.
   function automatic logic is_term(input logic [1:0] hdr, input logic [63:0] data);
      logic type_hit;
      case (data[7:0])
         BLOCK_TYPE_T0, BLOCK_TYPE_T1, BLOCK_TYPE_T2, BLOCK_TYPE_T3,
         BLOCK_TYPE_T4, BLOCK_TYPE_T5, BLOCK_TYPE_T6, BLOCK_TYPE_T7: type_hit = 1'b1;
         default: type_hit = 1'b0;
      endcase
      return (hdr == SYNC_CTRL) && type_hit;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head, extra-bit pointers and a free-space count.
module sync_fifo #(
   parameter int WIDTH = 66,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   space
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
   localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [AW:0]      space_reg;
   logic             push;
   logic             pop;

   // Full is judged on the pre-cycle state, so a same-cycle read never rescues a write.
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign push  = wr && !full;
   assign pop   = rd && !empty;
   assign head  = store[rd_ptr_reg[AW-1:0]];
   assign space = space_reg;

   // Storage is never reset; resetting the pointers is enough to discard contents.
   always_ff @(posedge clk) begin
      if (push) begin
         store[wr_ptr_reg[AW-1:0]] <= wr_data;
      end
   end

   // Pointers wrap naturally through the extra bit; space tracks post-cycle occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         space_reg  <= SP_FULL;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + SP_ONE;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + SP_ONE;
         if (push && !pop)      space_reg <= space_reg - SP_ONE;
         else if (pop && !push) space_reg <= space_reg + SP_ONE;
      end
   end

endmodule

// File: rtl/ipg_buf_sched.sv
// Merges a 66b net block stream with wide memory replies emitted as inter-packet-gap beats.
module ipg_buf_sched
   import ipg_pkg::*;
#(
   parameter int MEM_W        = 512,
   parameter int NET_DEPTH    = 8,
   parameter int MEM_DEPTH    = 4,
   parameter int PAUSE_THRESH = 2
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          net_wr,
   input  logic [1:0]                    net_hdr,
   input  logic [63:0]                   net_data,
   input  logic                          mem_wr,
   input  logic [MEM_W-1:0]              mem_data,
   output logic [1:0]                    tx_hdr,
   output logic [63:0]                   tx_data,
   output logic                          tx_ipg,
   output logic [$clog2(NET_DEPTH):0]    net_space,
   output logic [$clog2(MEM_DEPTH):0]    mem_space,
   output logic [1:0]                    tuser,
   output logic                          net_ovf,
   output logic                          mem_ovf,
   output logic                          underrun
);
   localparam int NB  = MEM_W / 64;
   localparam int BW  = $clog2(NB) + 1;
   localparam int NSW = $clog2(NET_DEPTH) + 1;
   localparam int MSW = $clog2(MEM_DEPTH) + 1;
   localparam logic GRANT_NET = 1'b0;
   localparam logic GRANT_MEM = 1'b1;
   localparam logic [NSW-1:0] NET_ONE = NSW'(1);
   localparam logic [MSW-1:0] MEM_ONE = MSW'(1);
   localparam logic [NSW-1:0] NET_THR = NSW'(PAUSE_THRESH);
   localparam logic [MSW-1:0] MEM_THR = MSW'(PAUSE_THRESH);

   logic [65:0]      net_head;
   logic             net_empty, net_full, net_rd;
   logic [MEM_W-1:0] mem_head;
   logic             mem_empty, mem_full, mem_rd;
   logic [NSW-1:0]   net_space_next;
   logic [MSW-1:0]   mem_space_next;

   state_t           state_reg;
   logic             last_grant_reg;
   logic [BW-1:0]    beat_reg;
   logic [BW-1:0]    beat_idx;
   logic             last_beat, head_term, grant_net, grant_mem;
   logic [63:0]      beats [NB];
   logic [63:0]      beat_word;

   logic [1:0]       tx_hdr_reg;
   logic [63:0]      tx_data_reg;
   logic             tx_ipg_reg, underrun_reg, net_ovf_reg, mem_ovf_reg;
   logic [1:0]       tuser_reg;

   sync_fifo #(.WIDTH(66), .DEPTH(NET_DEPTH)) u_net_fifo (
      .clk(clk), .reset_n(reset_n),
      .wr(net_wr), .wr_data({net_hdr, net_data}), .rd(net_rd),
      .head(net_head), .empty(net_empty), .full(net_full), .space(net_space)
   );

   sync_fifo #(.WIDTH(MEM_W), .DEPTH(MEM_DEPTH)) u_mem_fifo (
      .clk(clk), .reset_n(reset_n),
      .wr(mem_wr), .wr_data(mem_data), .rd(mem_rd),
      .head(mem_head), .empty(mem_empty), .full(mem_full), .space(mem_space)
   );

   // Beat 0 is the most significant 64 bits of the reply.
   for (genvar gi = 0; gi < NB; gi++) begin : g_beat
      assign beats[gi] = mem_head[MEM_W-1-64*gi -: 64];
   end

   // Grant, beat selection and pop strobes; the head is popped in the cycle it is emitted.
   always_comb begin
      beat_idx  = (state_reg == IPG) ? beat_reg + BW'(1) : '0;
      last_beat = (beat_idx == BW'(NB-1));
      beat_word = beats[0];
      for (int k = 1; k < NB; k++) begin
         if (beat_idx == BW'(k)) beat_word = beats[k];
      end
      head_term = is_term(net_head[65:64], net_head[63:0]);
      grant_net = (state_reg == IDLE) && !net_empty &&
                  (mem_empty || last_grant_reg == GRANT_MEM);
      grant_mem = (state_reg == IDLE) && !mem_empty && !grant_net;
      net_rd    = grant_net || ((state_reg == NET) && !net_empty);
      mem_rd    = (grant_mem || (state_reg == IPG)) && last_beat;
   end

   // Occupancy after this cycle's push and pop, so pause lines up with the space outputs.
   always_comb begin
      net_space_next = net_space;
      mem_space_next = mem_space;
      if (net_wr && !net_full)  net_space_next = net_space_next - NET_ONE;
      if (net_rd && !net_empty) net_space_next = net_space_next + NET_ONE;
      if (mem_wr && !mem_full)  mem_space_next = mem_space_next - MEM_ONE;
      if (mem_rd && !mem_empty) mem_space_next = mem_space_next + MEM_ONE;
   end

   // Registered pause levels and drop pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tuser_reg   <= 2'b00;
         net_ovf_reg <= 1'b0;
         mem_ovf_reg <= 1'b0;
      end else begin
         tuser_reg   <= {(mem_space_next <= MEM_THR), (net_space_next <= NET_THR)};
         net_ovf_reg <= net_wr && net_full;
         mem_ovf_reg <= mem_wr && mem_full;
      end
   end

   // Scheduler FSM with registered transmit outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         last_grant_reg <= GRANT_MEM;
         beat_reg       <= '0;
         tx_hdr_reg     <= SYNC_CTRL;
         tx_data_reg    <= IDLE_BLOCK;
         tx_ipg_reg     <= 1'b0;
         underrun_reg   <= 1'b0;
      end else begin
         underrun_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (grant_net) begin
                  tx_hdr_reg     <= net_head[65:64];
                  tx_data_reg    <= net_head[63:0];
                  tx_ipg_reg     <= 1'b0;
                  last_grant_reg <= GRANT_NET;
                  state_reg      <= head_term ? IDLE : NET;
               end else if (grant_mem) begin
                  tx_hdr_reg     <= SYNC_DATA;
                  tx_data_reg    <= beat_word;
                  tx_ipg_reg     <= 1'b1;
                  last_grant_reg <= GRANT_MEM;
                  beat_reg       <= '0;
                  state_reg      <= last_beat ? IDLE : IPG;
               end else begin
                  tx_hdr_reg  <= SYNC_CTRL;
                  tx_data_reg <= IDLE_BLOCK;
                  tx_ipg_reg  <= 1'b0;
               end
            end
            NET: begin
               tx_ipg_reg <= 1'b0;
               if (!net_empty) begin
                  tx_hdr_reg  <= net_head[65:64];
                  tx_data_reg <= net_head[63:0];
                  if (head_term) state_reg <= IDLE;
               end else begin
                  tx_hdr_reg   <= SYNC_CTRL;
                  tx_data_reg  <= ERR_BLOCK;
                  underrun_reg <= 1'b1;
               end
            end
            IPG: begin
               tx_hdr_reg  <= SYNC_DATA;
               tx_data_reg <= beat_word;
               tx_ipg_reg  <= 1'b1;
               beat_reg    <= beat_idx;
               if (last_beat) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign tx_hdr   = tx_hdr_reg;
   assign tx_data  = tx_data_reg;
   assign tx_ipg   = tx_ipg_reg;
   assign tuser    = tuser_reg;
   assign net_ovf  = net_ovf_reg;
   assign mem_ovf  = mem_ovf_reg;
   assign underrun = underrun_reg;

endmodule

// File: tb/tb_ipg_buf_sched.sv
// Bench for ipg_buf_sched: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_ipg_buf_sched;
   localparam int MEM_W        = 512;
   localparam int NET_DEPTH    = 8;
   localparam int MEM_DEPTH    = 4;
   localparam int PAUSE_THRESH = 2;
   localparam int NB           = MEM_W / 64;
   localparam logic [63:0] ERR_EXP = {{8{7'h1e}}, 8'h1e};

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  net_wr = 1'b0;
   logic [1:0]            net_hdr = 2'b00;
   logic [63:0]           net_data = '0;
   logic                  mem_wr = 1'b0;
   logic [MEM_W-1:0]      mem_data = '0;
   logic [1:0]            tx_hdr;
   logic [63:0]           tx_data;
   logic                  tx_ipg;
   logic [3:0]            net_space;
   logic [2:0]            mem_space;
   logic [1:0]            tuser;
   logic                  net_ovf, mem_ovf, underrun;

   int n_checks = 0;
   int n_fail   = 0;

   ipg_buf_sched #(
      .MEM_W(MEM_W), .NET_DEPTH(NET_DEPTH), .MEM_DEPTH(MEM_DEPTH), .PAUSE_THRESH(PAUSE_THRESH)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .net_wr(net_wr), .net_hdr(net_hdr), .net_data(net_data),
      .mem_wr(mem_wr), .mem_data(mem_data),
      .tx_hdr(tx_hdr), .tx_data(tx_data), .tx_ipg(tx_ipg),
      .net_space(net_space), .mem_space(mem_space), .tuser(tuser),
      .net_ovf(net_ovf), .mem_ovf(mem_ovf), .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [65:0]      nq[$];
   logic [MEM_W-1:0] mq[$];
   bit               in_frame   = 0;
   int               beats_left = 0;
   bit               last_mem   = 1;
   logic [1:0]       e_hdr  = 2'b01;
   logic [63:0]      e_data = 64'h1e;
   logic             e_ipg = 0, e_novf = 0, e_movf = 0, e_und = 0;
   logic [1:0]       e_tuser = 2'b00;
   int               e_nsp = NET_DEPTH;
   int               e_msp = MEM_DEPTH;

   function automatic bit term_blk(input logic [65:0] b);
      return (b[65:64] == 2'b01) &&
             (b[7:0] inside {8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff});
   endfunction

   function automatic logic [63:0] beat_of(input logic [MEM_W-1:0] r, input int k);
      logic [MEM_W-1:0] s;
      s = r >> (MEM_W - 64 - 64 * k);
      return s[63:0];
   endfunction

   function automatic logic [MEM_W-1:0] rand_reply();
      logic [MEM_W-1:0] r;
      r = '0;
      for (int k = 0; k < MEM_W / 32; k++) r = {r[MEM_W-33:0], 32'($urandom)};
      return r;
   endfunction

   task automatic model_reset();
      nq.delete(); mq.delete();
      in_frame = 0; beats_left = 0; last_mem = 1;
      e_hdr = 2'b01; e_data = 64'h1e; e_ipg = 0;
      e_nsp = NET_DEPTH; e_msp = MEM_DEPTH; e_tuser = 2'b00;
      e_novf = 0; e_movf = 0; e_und = 0;
   endtask

   task automatic emit_beat();
      e_hdr = 2'b10; e_ipg = 1;
      e_data = beat_of(mq[0], NB - beats_left);
      beats_left--;
      if (beats_left == 0) void'(mq.pop_front());
   endtask

   task automatic emit_net();
      logic [65:0] b;
      b = nq.pop_front();
      e_hdr = b[65:64]; e_data = b[63:0]; e_ipg = 0;
      in_frame = !term_blk(b);
   endtask

   task automatic model_step();
      bit nfull, mfull;
      nfull = (nq.size() == NET_DEPTH);
      mfull = (mq.size() == MEM_DEPTH);
      e_und = 0; e_ipg = 0; e_hdr = 2'b01; e_data = 64'h1e;
      if (in_frame) begin
         if (nq.size() > 0) emit_net();
         else begin e_data = ERR_EXP; e_und = 1; end
      end else if (beats_left > 0) begin
         emit_beat();
      end else if (nq.size() > 0 && (mq.size() == 0 || last_mem)) begin
         last_mem = 0;
         emit_net();
      end else if (mq.size() > 0) begin
         last_mem = 1;
         beats_left = NB;
         emit_beat();
      end
      e_novf = net_wr && nfull;
      e_movf = mem_wr && mfull;
      if (net_wr && !nfull) nq.push_back({net_hdr, net_data});
      if (mem_wr && !mfull) mq.push_back(mem_data);
      e_nsp = NET_DEPTH - nq.size();
      e_msp = MEM_DEPTH - mq.size();
      e_tuser = {(e_msp <= PAUSE_THRESH), (e_nsp <= PAUSE_THRESH)};
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) model_reset();
      else model_step();
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("tx_hdr",    64'(tx_hdr),    64'(e_hdr));
      chk("tx_data",   tx_data,        e_data);
      chk("tx_ipg",    64'(tx_ipg),    64'(e_ipg));
      chk("net_space", 64'(net_space), 64'(e_nsp));
      chk("mem_space", 64'(mem_space), 64'(e_msp));
      chk("tuser",     64'(tuser),     64'(e_tuser));
      chk("net_ovf",   64'(net_ovf),   64'(e_novf));
      chk("mem_ovf",   64'(mem_ovf),   64'(e_movf));
      chk("underrun",  64'(underrun),  64'(e_und));
   end

   // ---------------- stimulus ----------------
   task automatic put_net(input logic [1:0] h, input logic [63:0] d);
      net_wr = 1'b1; net_hdr = h; net_data = d;
   endtask

   task automatic pulse_reset();
      #2 reset_n = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got still running required finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [MEM_W-1:0] r6;
      logic [7:0]       tt [8];
      tt = '{8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff};

      repeat (3) @(negedge clk);
      chk("rst_tx_hdr",    64'(tx_hdr),    64'h1);
      chk("rst_tx_data",   tx_data,        64'h1e);
      chk("rst_net_space", 64'(net_space), 64'd8);
      chk("rst_mem_space", 64'(mem_space), 64'd4);
      chk("rst_tuser",     64'(tuser),     64'd0);
      reset_n = 1'b1;

      // Net frame forwarded two cycles after the first write.
      put_net(2'b01, 64'h78);                 @(negedge clk);
      put_net(2'b10, 64'hbb11223344556677);   @(negedge clk);
      chk("s1_start", tx_data, 64'h78);
      put_net(2'b01, 64'haa99);               @(negedge clk);
      chk("s1_data", tx_data, 64'hbb11223344556677);
      chk("s1_data_hdr", 64'(tx_hdr), 64'h2);
      net_wr = 1'b0;                          @(negedge clk);
      chk("s1_term", tx_data, 64'haa99);
      @(negedge clk);
      chk("s1_idle", tx_data, 64'h1e);

      // Single reply split into eight gap beats.
      mem_data = {64'hccccaaaaccccaaaa, {448{1'b1}}};
      mem_wr = 1'b1;                          @(negedge clk);
      mem_wr = 1'b0;
      chk("s2_space_held", 64'(mem_space), 64'd3);
      @(negedge clk);
      chk("s2_beat0", tx_data, 64'hccccaaaaccccaaaa);
      chk("s2_beat0_ipg", 64'(tx_ipg), 64'd1);
      @(negedge clk);
      chk("s2_beat1", tx_data, 64'hffffffffffffffff);
      repeat (6) @(negedge clk);
      chk("s2_beat7", tx_data, 64'hffffffffffffffff);
      chk("s2_space_back", 64'(mem_space), 64'd4);
      @(negedge clk);
      chk("s2_idle_ipg", 64'(tx_ipg), 64'd0);

      // Both sources loaded from reset: net first, then alternation.
      pulse_reset();
      put_net(2'b01, 64'h78); mem_data = rand_reply(); mem_wr = 1'b1; @(negedge clk);
      put_net(2'b01, 64'hff); mem_wr = 1'b0;                          @(negedge clk);
      chk("s3_net_first", tx_data, 64'h78);
      chk("s3_net_first_ipg", 64'(tx_ipg), 64'd0);
      net_wr = 1'b0;                                                  @(negedge clk);
      chk("s3_term", tx_data, 64'hff);
      @(negedge clk);
      chk("s3_reply_next", 64'(tx_ipg), 64'd1);
      repeat (10) @(negedge clk);
      put_net(2'b01, 64'h1278); mem_data = rand_reply(); mem_wr = 1'b1; @(negedge clk);
      put_net(2'b01, 64'h34cc); mem_data = rand_reply();                @(negedge clk);
      put_net(2'b01, 64'h5678); mem_wr = 1'b0;                          @(negedge clk);
      put_net(2'b01, 64'h78e1);                                         @(negedge clk);
      net_wr = 1'b0;
      repeat (30) @(negedge clk);

      // Underrun inside a frame, then recovery on terminate.
      put_net(2'b01, 64'h78);                 @(negedge clk);
      put_net(2'b10, 64'h0102030405060708);   @(negedge clk);
      net_wr = 1'b0;                          @(negedge clk);
      @(negedge clk);
      chk("s4_err_block", tx_data, ERR_EXP);
      chk("s4_underrun", 64'(underrun), 64'd1);
      repeat (3) @(negedge clk);
      put_net(2'b01, 64'hb4);                 @(negedge clk);
      net_wr = 1'b0;                          @(negedge clk);
      chk("s4_term", tx_data, 64'hb4);
      @(negedge clk);
      chk("s4_idle", tx_data, 64'h1e);

      // Net FIFO fills while a reply is being sent; ninth write dropped.
      pulse_reset();
      mem_data = rand_reply(); mem_wr = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         mem_wr = 1'b0;
         if (i == 5) chk("s5_tuser_off", 64'(tuser[0]), 64'd0);
         if (i == 6) begin
            chk("s5_space2", 64'(net_space), 64'd2);
            chk("s5_tuser_on", 64'(tuser[0]), 64'd1);
         end
         if (i == 8) chk("s5_space0", 64'(net_space), 64'd0);
         if (i == 7) put_net(2'b01, 64'h00cc);
         else        put_net(2'b10, 64'(i) * 64'h0101010101010101);
      end
      @(negedge clk);
      net_wr = 1'b0;
      chk("s5_ovf", 64'(net_ovf), 64'd1);
      repeat (12) @(negedge clk);

      // Reset during beat 3 of a reply.
      pulse_reset();
      r6 = rand_reply();
      mem_data = r6; mem_wr = 1'b1;           @(negedge clk);
      mem_wr = 1'b0; put_net(2'b01, 64'h78);  @(negedge clk);
      put_net(2'b10, 64'h55);                 @(negedge clk);
      net_wr = 1'b0;                          @(negedge clk);
      @(negedge clk);
      chk("s6_beat3", tx_data, beat_of(r6, 3));
      #1 reset_n = 1'b0;
      #1;
      chk("s6_rst_data", tx_data, 64'h1e);
      chk("s6_rst_ipg", 64'(tx_ipg), 64'd0);
      chk("s6_rst_nsp", 64'(net_space), 64'd8);
      chk("s6_rst_msp", 64'(mem_space), 64'd4);
      @(negedge clk);
      #2 reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("s6_after_idle", tx_data, 64'h1e);
      end

      // Randomised traffic.
      for (int c = 0; c < 2000; c++) begin
         net_wr = ($urandom_range(0, 99) < 40);
         case ($urandom_range(0, 3))
            0: begin net_hdr = 2'b01; net_data = {32'($urandom), 24'($urandom), tt[$urandom_range(0, 7)]}; end
            1: begin net_hdr = 2'b01; net_data = {32'($urandom), 24'($urandom), 8'h78}; end
            default: begin net_hdr = 2'b10; net_data = {32'($urandom), 32'($urandom)}; end
         endcase
         mem_wr = ($urandom_range(0, 99) < 8);
         mem_data = rand_reply();
         if (c == 1000) pulse_reset();
         @(negedge clk);
      end
      put_net(2'b01, 64'hd2); mem_wr = 1'b0;
      @(negedge clk);
      net_wr = 1'b0;
      repeat (60) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
